// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// FSM states, forward-select codes and register address width.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Producer/consumer register comparator; $0 never matches.
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic              regwrite_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic              use_i,
    output logic              match_o
);

    assign match_o = regwrite_i && use_i &&
                     (rd_i != '0) && (rd_i == rs_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline.
// Define FORWARDING_EN to enable EX operand forwarding.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_branch_taken_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_flush_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              hazard_err_o
);

    logic m_ex_rs, m_ex_rt, m_wb_rs, m_wb_rt;
    logic stall_cond, stall, flush;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    hazard_match u_ex_rs (.regwrite_i(ex_regwrite_i), .rd_i(ex_rd_i),
        .rs_i(id_rs_i), .use_i(id_use_rs_i), .match_o(m_ex_rs));
    hazard_match u_ex_rt (.regwrite_i(ex_regwrite_i), .rd_i(ex_rd_i),
        .rs_i(id_rt_i), .use_i(id_use_rt_i), .match_o(m_ex_rt));
    hazard_match u_wb_rs (.regwrite_i(wb_regwrite_i), .rd_i(wb_rd_i),
        .rs_i(id_rs_i), .use_i(id_use_rs_i), .match_o(m_wb_rs));
    hazard_match u_wb_rt (.regwrite_i(wb_regwrite_i), .rd_i(wb_rd_i),
        .rs_i(id_rt_i), .use_i(id_use_rt_i), .match_o(m_wb_rt));

`ifdef FORWARDING_EN
    logic f_mem_a, f_wb_a, f_mem_b, f_wb_b;

    // EX stage has no use bits, so consumers are always treated as reading
    hazard_match u_f_mem_a (.regwrite_i(mem_regwrite_i), .rd_i(mem_rd_i),
        .rs_i(ex_rs_i), .use_i(1'b1), .match_o(f_mem_a));
    hazard_match u_f_wb_a (.regwrite_i(wb_regwrite_i), .rd_i(wb_rd_i),
        .rs_i(ex_rs_i), .use_i(1'b1), .match_o(f_wb_a));
    hazard_match u_f_mem_b (.regwrite_i(mem_regwrite_i), .rd_i(mem_rd_i),
        .rs_i(ex_rt_i), .use_i(1'b1), .match_o(f_mem_b));
    hazard_match u_f_wb_b (.regwrite_i(wb_regwrite_i), .rd_i(wb_rd_i),
        .rs_i(ex_rt_i), .use_i(1'b1), .match_o(f_wb_b));

    assign stall_cond = (ex_memread_i && (m_ex_rs || m_ex_rt)) ||
                        m_wb_rs || m_wb_rt;
    assign fwd_a_raw = f_mem_a ? FWD_MEM : (f_wb_a ? FWD_WB : FWD_RF);
    assign fwd_b_raw = f_mem_b ? FWD_MEM : (f_wb_b ? FWD_WB : FWD_RF);
`else
    logic m_mem_rs, m_mem_rt;
    logic unused_ok;

    hazard_match u_mem_rs (.regwrite_i(mem_regwrite_i), .rd_i(mem_rd_i),
        .rs_i(id_rs_i), .use_i(id_use_rs_i), .match_o(m_mem_rs));
    hazard_match u_mem_rt (.regwrite_i(mem_regwrite_i), .rd_i(mem_rd_i),
        .rs_i(id_rt_i), .use_i(id_use_rt_i), .match_o(m_mem_rt));

    assign stall_cond = m_ex_rs || m_ex_rt || m_mem_rs ||
                        m_mem_rt || m_wb_rs || m_wb_rt;
    assign fwd_a_raw = FWD_RF;
    assign fwd_b_raw = FWD_RF;
    assign unused_ok = ^{ex_rs_i, ex_rt_i, ex_memread_i};
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       wdog_q, wdog_d;
    logic             err_q, err_d;

    always_comb begin
        flush = 1'b0;
        stall = 1'b0;
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (!rst_i) begin
            flush = mem_branch_taken_i;
            stall = stall_cond && !mem_branch_taken_i;
            fwd_a_o = fwd_a_raw;
            fwd_b_o = fwd_b_raw;
        end
        pc_write_o     = !stall;
        if_id_write_o  = !stall;
        if_id_flush_o  = flush;
        id_ex_flush_o  = flush || stall;
        ex_mem_flush_o = flush;
    end

    always_comb begin
        state_d = flush ? ST_FLUSH : (stall ? ST_STALL : ST_RUN);
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
        // Watchdog saturates at 3; a stall seen at 3 is the fourth in a row
        wdog_d = 2'd0;
        if (stall)
            wdog_d = (wdog_q == 2'd3) ? 2'd3 : wdog_q + 2'd1;
        err_d = err_q || (stall && (wdog_q == 2'd3));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wdog_q      <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign hazard_err_o = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CNT_W=4).
// Expectations adapt to the FORWARDING_EN build option.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic       mem_regwrite, mem_br, wb_regwrite;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0] fwd_a, fwd_b, state;
    logic [3:0] stall_cnt, flush_cnt;
    logic       herr;

    int tests = 0;
    int fails = 0;

    pipe_hazard_ctrl #(.CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
        .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .mem_branch_taken_i(mem_br),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .ex_mem_flush_o(ex_mem_flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .hazard_err_o(herr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; mem_br = 0;
        wb_rd = 0; wb_regwrite = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    // ID reads $7 while WB writes $7: stalls in both builds
    task automatic wb_hazard();
        idle();
        id_rs = 7; id_use_rs = 1;
        wb_rd = 7; wb_regwrite = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        wb_hazard();
        mem_rd = 7; mem_regwrite = 1; ex_rs = 7;
        #1;
        tests++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            fails++;
            $display("FAIL reset_we pc=%b ifid=%b want 1 1", pc_write, if_id_write);
        end
        tests++;
        if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flush got %b%b%b want 000",
                     if_id_flush, id_ex_flush, ex_mem_flush);
        end
        tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL reset_fwd got %b/%b want 00/00", fwd_a, fwd_b);
        end
        step();
        tests++;
        if (state !== 2'b00 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || herr !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs st=%b sc=%0d fc=%0d err=%b want 00 0 0 0",
                     state, stall_cnt, flush_cnt, herr);
        end
        rst = 0;
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 2;
        id_rs = 2; id_use_rs = 1;
        #1;
        tests++;
        if ({pc_write, if_id_write, id_ex_flush, if_id_flush} !== 4'b0010) begin
            fails++;
            $display("FAIL load_use_ctl got pc=%b ifid=%b idex=%b ifflush=%b want 0 0 1 0",
                     pc_write, if_id_write, id_ex_flush, if_id_flush);
        end
        step();
        tests++;
        if (state !== 2'b01) begin
            fails++;
            $display("FAIL load_use_state got %b want 01", state);
        end
        idle();
        #1;
        tests++;
        if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) begin
            fails++;
            $display("FAIL load_use_release pc=%b idex=%b want 1 0", pc_write, id_ex_flush);
        end
        step();
        tests++;
        if (state !== 2'b00 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL load_use_after st=%b sc=%0d want 00 1", state, stall_cnt);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
        mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 0;
        id_use_rs = 1; id_use_rt = 1;
        #1;
        tests++;
        if (pc_write !== 1'b1 || id_ex_flush !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL zero_reg pc=%b idex=%b fa=%b fb=%b want 1 0 00 00",
                     pc_write, id_ex_flush, fwd_a, fwd_b);
        end
        idle();
        wb_hazard();
        id_use_rs = 0;
        #1;
        tests++;
        if (pc_write !== 1'b1) begin
            fails++;
            $display("FAIL use_bit pc=%b want 1", pc_write);
        end
        idle();
        ex_regwrite = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1;
        #1;
        tests++;
`ifdef FORWARDING_EN
        if (pc_write !== 1'b1) begin
`else
        if (pc_write !== 1'b0) begin
`endif
            fails++;
            $display("FAIL rt_match pc=%b", pc_write);
        end
        idle();
    endtask

    task automatic test_forward();
        do_reset();
        mem_regwrite = 1; mem_rd = 3; wb_regwrite = 1; wb_rd = 3;
        ex_rs = 3; ex_rt = 4;
        #1;
        tests++;
`ifdef FORWARDING_EN
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
`else
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
`endif
            fails++;
            $display("FAIL fwd_mem fa=%b fb=%b", fwd_a, fwd_b);
        end
        mem_rd = 5; ex_rt = 5;
        #1;
        tests++;
`ifdef FORWARDING_EN
        if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
`else
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
`endif
            fails++;
            $display("FAIL fwd_wb fa=%b fb=%b", fwd_a, fwd_b);
        end
        idle();
    endtask

    task automatic test_flush_priority();
        do_reset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 2;
        id_rs = 2; id_use_rs = 1; mem_br = 1;
        #1;
        tests++;
        if ({if_id_flush, id_ex_flush, ex_mem_flush, pc_write, if_id_write} !== 5'b11111) begin
            fails++;
            $display("FAIL flush_ctl got %b%b%b pc=%b ifid=%b want 111 1 1",
                     if_id_flush, id_ex_flush, ex_mem_flush, pc_write, if_id_write);
        end
        step();
        tests++;
        if (state !== 2'b10 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL flush_regs st=%b fc=%0d sc=%0d want 10 1 0",
                     state, flush_cnt, stall_cnt);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_stall;
`ifdef FORWARDING_EN
        exp_stall = 4'b0100;
`else
        exp_stall = 4'b0111;
`endif
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle();
            id_rs = 4; id_use_rs = 1;
            if (c == 0) begin ex_rd = 4; ex_regwrite = 1; end
            if (c == 1) begin mem_rd = 4; mem_regwrite = 1; end
            if (c == 2) begin wb_rd = 4; wb_regwrite = 1; end
            #1;
            tests++;
            if (pc_write !== !exp_stall[c]) begin
                fails++;
                $display("FAIL dep_cycle%0d pc=%b want %b", c, pc_write, !exp_stall[c]);
            end
            step();
        end
        tests++;
        if (herr !== 1'b0 || stall_cnt !== ((exp_stall[0] + exp_stall[1]) + exp_stall[2])) begin
            fails++;
            $display("FAIL dep_totals err=%b sc=%0d", herr, stall_cnt);
        end
        idle();
    endtask

    task automatic test_watchdog();
        do_reset();
        wb_hazard();
        repeat (3) step();
        tests++;
        if (herr !== 1'b0) begin
            fails++;
            $display("FAIL wdog_3 err=%b want 0", herr);
        end
        step();
        tests++;
        if (herr !== 1'b1) begin
            fails++;
            $display("FAIL wdog_4 err=%b want 1", herr);
        end
        idle();
        repeat (3) step();
        tests++;
        if (herr !== 1'b1 || state !== 2'b00) begin
            fails++;
            $display("FAIL wdog_sticky err=%b st=%b want 1 00", herr, state);
        end
        do_reset();
        wb_hazard();
        repeat (3) step();
        mem_br = 1;
        step();
        mem_br = 0;
        repeat (3) step();
        tests++;
        if (herr !== 1'b0 || stall_cnt !== 4'd6) begin
            fails++;
            $display("FAIL wdog_flush_clear err=%b sc=%0d want 0 6", herr, stall_cnt);
        end
        rst = 1;
        step();
        tests++;
        if (state !== 2'b00 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL mid_stall_reset st=%b sc=%0d fc=%0d want 00 0 0",
                     state, stall_cnt, flush_cnt);
        end
        rst = 0;
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        wb_hazard();
        repeat (20) step();
        tests++;
        if (stall_cnt !== 4'd15 || state !== 2'b01) begin
            fails++;
            $display("FAIL stall_sat sc=%0d st=%b want 15 01", stall_cnt, state);
        end
        idle();
        mem_br = 1;
        repeat (18) step();
        tests++;
        if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
            fails++;
            $display("FAIL flush_sat fc=%0d sc=%0d want 15 15", flush_cnt, stall_cnt);
        end
        rst = 1;
        step();
        tests++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || state !== 2'b00 || herr !== 1'b0) begin
            fails++;
            $display("FAIL sat_reset sc=%0d fc=%0d st=%b err=%b want 0 0 00 0",
                     stall_cnt, flush_cnt, state, herr);
        end
        rst = 0;
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_forward();
        test_flush_priority();
        test_back_to_back();
        test_watchdog();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
